receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_pkg.sv | 13 +
 rtl/receiver.sv | 113 +++++++++++
 tb/tb_receiver.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// Shared types and defaults for the serial frame receiver.
// The STOP state is only reachable when RECEIVER_STOP_CHECK_EN is defined.
package receiver_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/receiver.sv
// Serial receiver: one data bit per clk, start bit low, MSB-first into a shift register.
// Optional stop-bit check with framing-error flag via `define RECEIVER_STOP_CHECK_EN.
module receiver
    import receiver_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] data
`ifdef RECEIVER_STOP_CHECK_EN
    ,
    output logic                 ferr
`endif
);

    // Counter holds 0..DATA_BITS-1 within a frame; one extra bit keeps it from wrapping.
    localparam int                CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_rdy;

    state_t                 w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [DATA_BITS-1:0]   w_data_next;
    logic                   w_rdy_next;

`ifdef RECEIVER_STOP_CHECK_EN
    logic                   r_ferr;
    logic                   w_ferr_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_rdy   <= 1'b0;
`ifdef RECEIVER_STOP_CHECK_EN
            r_ferr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_data  <= w_data_next;
            r_rdy   <= w_rdy_next;
`ifdef RECEIVER_STOP_CHECK_EN
            r_ferr  <= w_ferr_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_rdy_next   = r_rdy;
`ifdef RECEIVER_STOP_CHECK_EN
        w_ferr_next  = r_ferr;
`endif
        case (r_state)
            IDLE: begin
                // Old data is deliberately kept; it shifts out as the new frame arrives.
                if (!rx) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                    w_rdy_next   = 1'b0;
`ifdef RECEIVER_STOP_CHECK_EN
                    w_ferr_next  = 1'b0;
`endif
                end
            end
            DATA: begin
                w_data_next = {r_data[DATA_BITS-2:0], rx};
                if (r_cnt == LAST_BIT) begin
`ifdef RECEIVER_STOP_CHECK_EN
                    w_state_next = STOP;
`else
                    w_state_next = IDLE;
                    w_rdy_next   = 1'b1;
`endif
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
`ifdef RECEIVER_STOP_CHECK_EN
            STOP: begin
                w_state_next = IDLE;
                if (rx) begin
                    w_rdy_next  = 1'b1;
                end else begin
                    w_ferr_next = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign data = r_data;
    assign rdy  = r_rdy;
`ifdef RECEIVER_STOP_CHECK_EN
    assign ferr = r_ferr;
`endif

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver (DATA_BITS=8): stimulus queues expected data/rdy/ferr,
// a negedge monitor pops and compares against the DUT outputs.
module tb_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rdy;
    logic [7:0] data;
    logic       ferr;

    typedef struct {
        logic [7:0] data;
        logic       rdy;
        logic       ferr;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    receiver #(.DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rdy   (rdy),
        .data  (data)
`ifdef RECEIVER_STOP_CHECK_EN
        ,
        .ferr  (ferr)
`endif
    );

`ifndef RECEIVER_STOP_CHECK_EN
    assign ferr = 1'b0;
`endif

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Monitor: outputs are stable at negedge; every queued expectation is checked there.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (data !== e.data || rdy !== e.rdy || ferr !== e.ferr) begin
                n_err++;
                $display("FAIL %s: got data=%02h rdy=%b ferr=%b, expected data=%02h rdy=%b ferr=%b",
                         e.name, data, rdy, ferr, e.data, e.rdy, e.ferr);
            end else begin
                $display("ok   %s: data=%02h rdy=%b ferr=%b", e.name, data, rdy, ferr);
            end
        end
    end

    task automatic expect_out(input logic [7:0] d, input logic r, input logic f, input string name);
        exp_t e;
        e.data = d;
        e.rdy  = r;
        e.ferr = f;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Present one rx value for exactly one rising edge.
    task automatic bit_in(input logic b);
        @(negedge clk);
        rx = b;
        @(posedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bit_in(v[i]);
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        rx    = 1'b1;
        rst_n = 1'b0;
        expect_out(8'h00, 1'b0, 1'b0, name);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no end of stimulus, expected finish before time 20000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rx    = 1'b1;
        rst_n = 1'b0;

        do_reset("reset");
        repeat (5) bit_in(1'b1);
        expect_out(8'h00, 1'b0, 1'b0, "idle_after_reset");

`ifndef RECEIVER_STOP_CHECK_EN
        bit_in(1'b0);
        bit_in(1'b1);
        expect_out(8'h01, 1'b0, 1'b0, "partial_1bit");
        repeat (2) bit_in(1'b1);
        expect_out(8'h07, 1'b0, 1'b0, "partial_3bit");
        repeat (2) bit_in(1'b0);
        expect_out(8'h1C, 1'b0, 1'b0, "partial_5bit");
        repeat (3) bit_in(1'b0);
        expect_out(8'hE0, 1'b1, 1'b0, "frame_done_e0");
        repeat (5) bit_in(1'b1);
        expect_out(8'hE0, 1'b1, 1'b0, "hold_idle");
        bit_in(1'b0);
        bit_in(1'b1);
        expect_out(8'hC1, 1'b0, 1'b0, "restart_c1");
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        expect_out(8'h0A, 1'b0, 1'b0, "four_bits_0a");
        do_reset("reset_mid_frame");
        bit_in(1'b1);
        expect_out(8'h00, 1'b0, 1'b0, "post_reset_idle");
        bit_in(1'b0);
        send_bits(8'hA5, 8);
        expect_out(8'hA5, 1'b1, 1'b0, "frame_a5");
        bit_in(1'b0);
        expect_out(8'hA5, 1'b0, 1'b0, "b2b_start");
        send_bits(8'h3C, 7);
        expect_out(8'h9E, 1'b0, 1'b0, "seven_bits_no_rdy");
        bit_in(1'b0);
        expect_out(8'h3C, 1'b1, 1'b0, "frame_3c");
        repeat (3) bit_in(1'b1);
        expect_out(8'h3C, 1'b1, 1'b0, "hold_3c");
`else
        bit_in(1'b0);
        send_bits(8'h5A, 8);
        expect_out(8'h5A, 1'b0, 1'b0, "wait_stop");
        bit_in(1'b1);
        expect_out(8'h5A, 1'b1, 1'b0, "stop_ok");
        bit_in(1'b1);
        expect_out(8'h5A, 1'b1, 1'b0, "hold_after_stop");
        bit_in(1'b0);
        expect_out(8'h5A, 1'b0, 1'b0, "start_clears_rdy");
        send_bits(8'h5A, 8);
        expect_out(8'h5A, 1'b0, 1'b0, "wait_stop2");
        bit_in(1'b0);
        expect_out(8'h5A, 1'b0, 1'b1, "stop_bad_ferr");
        bit_in(1'b1);
        expect_out(8'h5A, 1'b0, 1'b1, "ferr_held");
        bit_in(1'b0);
        expect_out(8'h5A, 1'b0, 1'b0, "start_clears_ferr");
        send_bits(8'hC3, 8);
        bit_in(1'b1);
        expect_out(8'hC3, 1'b1, 1'b0, "frame_c3");
        bit_in(1'b0);
        send_bits(8'h0F, 3);
        do_reset("reset_mid_frame");
        bit_in(1'b1);
        expect_out(8'h00, 1'b0, 1'b0, "post_reset_idle");
`endif

        @(negedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
